hi_flite_reader_tx: RTL and testbench

//  Initiator-side ISO/IEC 18092 (FeliCa / NFC-F) frame transmitter, the counterpart of the tag-side FeliCa demod/mod path.

---
 rtl/hi_flite_pkg.sv | 23 ++
 rtl/hi_flite_reader_tx_crc.sv | 25 ++
 rtl/hi_flite_reader_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_hi_flite_reader_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_flite_pkg.sv
// Shared constants and types for the FeliCa / NFC-F initiator transmitter.
package hi_flite_pkg;

    // Sync word sent after the preamble, high byte first
    localparam logic [15:0] FELICA_SYNC = 16'hB24D;

    // Half-bit lengths in carrier clocks
    localparam int HALF_212 = 32;
    localparam int HALF_424 = 16;

    // CRC-16/CCITT generator polynomial
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        DATA     = 3'd3,
        CRC      = 3'd4
    } state_e;

endpackage

// File: rtl/hi_flite_reader_tx_crc.sv
// Combinational byte-wide CRC-16/CCITT step (MSB first, no reflection).
module felica_crc16
    import hi_flite_pkg::*;
(
    input  logic [15:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc_out
);

    logic [15:0] w_c;

    // Fold the byte into the high end, then run eight polynomial shifts
    always_comb begin
        w_c = i_crc_in ^ {i_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (w_c[15]) begin
                w_c = {w_c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_c = {w_c[14:0], 1'b0};
            end
        end
        o_crc_out = w_c;
    end

endmodule

// File: rtl/hi_flite_reader_tx.sv
// FeliCa / NFC-F initiator frame transmitter: preamble, sync, payload and
// optional CRC-16, Manchester coded onto mod_out.
//
// Handshake: a payload byte moves into the holding register on any rising
// edge where tx_valid and tx_ready are both high; tx_ready depends only on
// registered state, and tx_data is never sampled while tx_ready is low.
module hi_flite_reader_tx
    import hi_flite_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 6,
    parameter bit CRC_EN         = 1'b1
)
(
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       speed,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mod_out,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output state_e     o_dbg_state
);

    localparam logic [7:0] PRE_LAST   = 8'(PREAMBLE_BYTES - 1);
    localparam logic [5:0] HALF_M1_LO = 6'(HALF_212 - 1);
    localparam logic [5:0] BIT_M1_LO  = 6'(2 * HALF_212 - 1);
    localparam logic [5:0] HALF_M1_HI = 6'(HALF_424 - 1);
    localparam logic [5:0] BIT_M1_HI  = 6'(2 * HALF_424 - 1);

    state_e      r_state,     w_state_n;
    logic [5:0]  r_cnt,       w_cnt_n;
    logic [2:0]  r_bit,       w_bit_n;
    logic [7:0]  r_byte,      w_byte_n;
    logic [7:0]  r_shift,     w_shift_n;
    logic [7:0]  r_hold,      w_hold_n;
    logic        r_hold_full, w_hold_full_n;
    logic        r_hold_last, w_hold_last_n;
    logic        r_last_acc,  w_last_acc_n;
    logic        r_sh_last,   w_sh_last_n;
    logic [15:0] r_crc,       w_crc_n;
    logic        r_speed,     w_speed_n;
    logic        r_mod,       w_mod_n;
    logic        r_busy,      w_busy_n;
    logic        r_done,      w_done_n;
    logic        r_und,       w_und_n;

    logic [15:0] w_crc_next;
    logic [5:0]  w_half_m1;
    logic [5:0]  w_bit_m1;
    logic        w_accept;
    logic        w_take;
    logic        w_end;

    felica_crc16 u_crc (
        .i_crc_in  (r_crc),
        .i_data    (r_hold),
        .o_crc_out (w_crc_next)
    );

    assign w_half_m1   = r_speed ? HALF_M1_HI : HALF_M1_LO;
    assign w_bit_m1    = r_speed ? BIT_M1_HI  : BIT_M1_LO;
    assign tx_ready    = r_busy & ~r_hold_full & ~r_last_acc;
    assign w_accept    = tx_valid & tx_ready;
    assign mod_out     = r_mod;
    assign busy        = r_busy;
    assign done        = r_done;
    assign underrun    = r_und;
    assign o_dbg_state = r_state;

    // Next-state, bit timing, byte sequencing and handshake decisions
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_bit_n       = r_bit;
        w_byte_n      = r_byte;
        w_shift_n     = r_shift;
        w_hold_n      = r_hold;
        w_hold_full_n = r_hold_full;
        w_hold_last_n = r_hold_last;
        w_last_acc_n  = r_last_acc;
        w_sh_last_n   = r_sh_last;
        w_crc_n       = r_crc;
        w_speed_n     = r_speed;
        w_mod_n       = r_mod;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        w_und_n       = 1'b0;
        w_take        = 1'b0;
        w_end         = 1'b0;

        if (r_state == IDLE) begin
            if (start) begin
                // First preamble bit begins in the next cycle; 0x00 starts low
                w_state_n     = PREAMBLE;
                w_speed_n     = speed;
                w_cnt_n       = 6'd0;
                w_bit_n       = 3'd0;
                w_byte_n      = 8'd0;
                w_shift_n     = 8'h00;
                w_mod_n       = 1'b0;
                w_busy_n      = 1'b1;
                w_hold_full_n = 1'b0;
                w_hold_last_n = 1'b0;
                w_last_acc_n  = 1'b0;
                w_sh_last_n   = 1'b0;
                w_crc_n       = 16'h0000;
            end
        end else begin
            if (w_accept) begin
                w_hold_n      = tx_data;
                w_hold_full_n = 1'b1;
                w_hold_last_n = tx_last;
                w_last_acc_n  = r_last_acc | tx_last;
            end

            w_cnt_n = r_cnt + 6'd1;
            if (r_cnt == w_half_m1) begin
                w_mod_n = ~r_shift[7];
            end

            if (r_cnt == w_bit_m1) begin
                w_cnt_n = 6'd0;
                if (r_bit != 3'd7) begin
                    w_bit_n   = r_bit + 3'd1;
                    w_shift_n = {r_shift[6:0], 1'b0};
                    w_mod_n   = r_shift[6];
                end else begin
                    // Byte boundary: choose the next byte to put on air
                    w_bit_n = 3'd0;
                    case (r_state)
                        PREAMBLE: begin
                            if (r_byte == PRE_LAST) begin
                                w_state_n = SYNC;
                                w_byte_n  = 8'd0;
                                w_shift_n = FELICA_SYNC[15:8];
                            end else begin
                                w_byte_n  = r_byte + 8'd1;
                                w_shift_n = 8'h00;
                            end
                        end
                        SYNC: begin
                            if (r_byte == 8'd0) begin
                                w_byte_n  = 8'd1;
                                w_shift_n = FELICA_SYNC[7:0];
                            end else begin
                                w_take = 1'b1;
                            end
                        end
                        DATA: w_take = 1'b1;
                        CRC: begin
                            if (r_byte == 8'd0) begin
                                w_byte_n  = 8'd1;
                                w_shift_n = r_crc[7:0];
                            end else begin
                                w_end = 1'b1;
                            end
                        end
                        default: w_end = 1'b1;
                    endcase

                    if (w_take) begin
                        if (r_state == DATA && r_sh_last) begin
                            if (CRC_EN) begin
                                w_state_n = CRC;
                                w_byte_n  = 8'd0;
                                w_shift_n = r_crc[15:8];
                            end else begin
                                w_end = 1'b1;
                            end
                        end else if (r_hold_full) begin
                            w_state_n     = DATA;
                            w_shift_n     = r_hold;
                            w_crc_n       = w_crc_next;
                            w_hold_full_n = 1'b0;
                            w_sh_last_n   = r_hold_last;
                        end else begin
                            // Payload starved before tx_last: abandon the frame
                            w_state_n     = IDLE;
                            w_busy_n      = 1'b0;
                            w_und_n       = 1'b1;
                            w_crc_n       = 16'h0000;
                            w_hold_full_n = 1'b0;
                        end
                    end

                    w_mod_n = w_und_n ? 1'b0 : w_shift_n[7];

                    if (w_end) begin
                        w_state_n = IDLE;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                        w_crc_n   = 16'h0000;
                        w_mod_n   = 1'b0;
                    end
                end
            end
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_bit       <= 3'd0;
            r_byte      <= 8'd0;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_last_acc  <= 1'b0;
            r_sh_last   <= 1'b0;
            r_crc       <= 16'h0000;
            r_speed     <= 1'b0;
            r_mod       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_und       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit       <= w_bit_n;
            r_byte      <= w_byte_n;
            r_shift     <= w_shift_n;
            r_hold      <= w_hold_n;
            r_hold_full <= w_hold_full_n;
            r_hold_last <= w_hold_last_n;
            r_last_acc  <= w_last_acc_n;
            r_sh_last   <= w_sh_last_n;
            r_crc       <= w_crc_n;
            r_speed     <= w_speed_n;
            r_mod       <= w_mod_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_und       <= w_und_n;
        end
    end

endmodule

// File: tb/tb_hi_flite_reader_tx.sv
// Self-checking bench for hi_flite_reader_tx: captures the mod_out waveform
// of whole frames and compares it against the on-air byte list and
// Manchester waveform derived from the frame rules.
module tb_hi_flite_reader_tx;
    import hi_flite_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       speed = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;

    logic   ready_a, mod_a, busy_a, done_a, und_a;
    logic   ready_b, mod_b, busy_b, done_b, und_b;
    state_e st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pay [16];
    logic       tr_q [$];
    logic [7:0] exp_q [$];
    int         busy_len, done_cnt, und_cnt, post_bad, timeout, aborted;

    // CRC_EN=1 instance
    hi_flite_reader_tx #(.PREAMBLE_BYTES(6), .CRC_EN(1'b1)) dut_a (
        .ck_1356meg (clk),
        .rst        (rst),
        .speed      (speed),
        .start      (start_a),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (ready_a),
        .mod_out    (mod_a),
        .busy       (busy_a),
        .done       (done_a),
        .underrun   (und_a),
        .o_dbg_state(st_a)
    );

    // CRC_EN=0 instance
    hi_flite_reader_tx #(.PREAMBLE_BYTES(6), .CRC_EN(1'b0)) dut_b (
        .ck_1356meg (clk),
        .rst        (rst),
        .speed      (speed),
        .start      (start_b),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (ready_b),
        .mod_out    (mod_b),
        .busy       (busy_b),
        .done       (done_b),
        .underrun   (und_b),
        .o_dbg_state(st_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC-16/CCITT, bit-serial LFSR over the first n payload bytes
    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < n; k++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ pay[k][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Read byte k back from the captured waveform, mid first half of each bit
    function automatic logic [7:0] decode_byte(input int k, input int h);
        logic [7:0] b;
        int         idx;
        b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            idx = (k * 8 + j) * 2 * h + h / 2;
            b = {b[6:0], (idx < tr_q.size()) ? tr_q[idx] : 1'b0};
        end
        return b;
    endfunction

    // Drive one frame and capture its waveform. avail < n starves the payload.
    task automatic run_frame(input bit sel, input bit spd, input int n, input int avail,
                             input int delay, input bit disturb, input int abort_cyc);
        int  pi;
        int  cyc;
        int  post;
        bit  seen;
        bit  fin;
        logic m, b, d, u, r;
        pi = 0; cyc = 0; post = 0; seen = 0; fin = 0;
        tr_q.delete();
        busy_len = 0; done_cnt = 0; und_cnt = 0; post_bad = 0; timeout = 0; aborted = 0;
        @(negedge clk);
        speed = spd;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (!fin) begin
            m = sel ? mod_b : mod_a;
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            u = sel ? und_b : und_a;
            r = sel ? ready_b : ready_a;
            if (b) begin
                busy_len++;
                tr_q.push_back(m);
                seen = 1;
            end else if (seen) begin
                post++;
                if (m) post_bad++;
            end
            done_cnt += int'(d);
            und_cnt  += int'(u);
            if (post >= 4) fin = 1;
            if ((!seen && cyc > 5) || cyc > 20000) begin
                timeout = 1;
                fin = 1;
            end
            if (disturb && !fin) begin
                if (sel) start_b = (cyc == 6 * 512 + 100); else start_a = (cyc == 6 * 512 + 100);
                if (cyc % 700 == 350) speed = ~speed;
            end
            if (!fin && abort_cyc > 0 && cyc >= abort_cyc && m) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_mod", sel ? mod_b : mod_a, 1'b0);
                check("async_rst_busy", sel ? busy_b : busy_a, 1'b0);
                check("async_rst_ready", sel ? ready_b : ready_a, 1'b0);
                tx_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                fin = 1;
            end
            if (!fin) begin
                tx_valid = (pi < avail) && (cyc >= delay);
                tx_data  = (pi < avail) ? pay[pi] : 8'h00;
                tx_last  = (pi == n - 1);
                if (tx_valid && r) pi++;
                @(negedge clk);
                cyc++;
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
    endtask

    // Compare the captured frame with the expected on-air content
    task automatic check_frame(input bit sel, input bit spd, input int n, input int avail);
        int         h;
        bit         und;
        int         m;
        int         err;
        int         bad_runs;
        int         run;
        int         explen;
        logic [15:0] c;
        logic       e;
        logic       bitv;
        h   = spd ? HALF_424 : HALF_212;
        und = (avail < n);
        exp_q.delete();
        repeat (6) exp_q.push_back(8'h00);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'h4D);
        m = und ? avail : n;
        for (int k = 0; k < m; k++) exp_q.push_back(pay[k]);
        if (!und && !sel) begin
            c = crc_ref(n);
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
        end
        explen = exp_q.size() * 16 * h;
        check("timeout", timeout, 0);
        check("busy_len", busy_len, explen);
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("byte%0d", k), decode_byte(k, h), exp_q[k]);
        err = 0;
        for (int i = 0; i < tr_q.size() && i < explen; i++) begin
            bitv = exp_q[i / (16 * h)][7 - (i % (16 * h)) / (2 * h)];
            e = ((i % (2 * h)) < h) ? bitv : ~bitv;
            if (tr_q[i] !== e) err++;
        end
        check("trace_err", err, 0);
        bad_runs = 0;
        run = 0;
        for (int i = 0; i < tr_q.size(); i++) begin
            run++;
            if (i == tr_q.size() - 1 || tr_q[i + 1] !== tr_q[i]) begin
                if (run % h != 0) bad_runs++;
                run = 0;
            end
        end
        check("run_len", bad_runs, 0);
        check("done_cnt", done_cnt, und ? 0 : 1);
        check("underrun_cnt", und_cnt, und ? 1 : 0);
        check("post_mod", post_bad, 0);
    endtask

    initial begin
        int n;
        bit s, sp;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mod_a", mod_a, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_ready_a", ready_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_und_a", und_a, 1'b0);
        check("rst_state_a", st_a, IDLE);
        check("rst_mod_b", mod_b, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Polling payload at 212 kbps
        pay[0] = 8'h06; pay[1] = 8'h00; pay[2] = 8'hFF;
        pay[3] = 8'hFF; pay[4] = 8'h00; pay[5] = 8'h00;
        run_frame(0, 0, 6, 6, 0, 0, -1);
        check_frame(0, 0, 6, 6);
        check("crc_hi_air", decode_byte(14, HALF_212), 8'h09);
        check("crc_lo_air", decode_byte(15, HALF_212), 8'h21);

        // Same payload at 424 kbps
        run_frame(0, 1, 6, 6, 0, 0, -1);
        check_frame(0, 1, 6, 6);
        check("busy_424", busy_len, 4096);

        // Payload stalls after two bytes
        run_frame(0, 0, 6, 2, 0, 0, -1);
        check_frame(0, 0, 6, 2);
        check("state_after_und", st_a, IDLE);

        // Reset in DATA, then a clean frame
        run_frame(0, 0, 6, 6, 0, 0, 8 * 512 + 200);
        check("aborted", aborted, 1);
        run_frame(0, 0, 6, 6, 0, 0, -1);
        check_frame(0, 0, 6, 6);

        // Extra start during SYNC and speed toggling mid-frame
        run_frame(0, 0, 6, 6, 0, 1, -1);
        check_frame(0, 0, 6, 6);

        // CRC_EN=0, single byte 0xA5
        pay[0] = 8'hA5;
        run_frame(1, 0, 1, 1, 0, 0, -1);
        check_frame(1, 0, 1, 1);
        check("a5_bit7_first_half", (tr_q.size() > 8 * 512) ? tr_q[8 * 512] : 1'b0, 1'b1);

        // Randomized frames
        repeat (3) begin
            n  = $urandom_range(1, 4);
            s  = 1'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) pay[k] = 8'($urandom_range(0, 255));
            run_frame(s, sp, n, n, $urandom_range(0, 1500), 0, -1);
            check_frame(s, sp, n, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
